// File: rtl/imm_pkg.sv
// Immediate format codes shared by the instruction encoder and the decode-side
// immediate extender, plus the request payload carried through the encoder pipeline.
package imm_pkg;

    localparam logic [2:0] IMM_I_LOAD = 3'b000;
    localparam logic [2:0] IMM_I_ALU  = 3'b001;
    localparam logic [2:0] IMM_SHAMT  = 3'b010;
    localparam logic [2:0] IMM_S      = 3'b011;
    localparam logic [2:0] IMM_U      = 3'b100;
    localparam logic [2:0] IMM_B      = 3'b101;
    localparam logic [2:0] IMM_I_JALR = 3'b110;
    localparam logic [2:0] IMM_J      = 3'b111;

    typedef struct packed {
        logic [2:0]  src;
        logic [31:0] imm;
        logic [31:0] base;
    } enc_req_t;

    // True when every bit from lsb upward equals the sign bit, i.e. the value
    // survives truncation to a (lsb+1)-bit signed field.
    function automatic logic upper_uniform(input logic [31:0] v, input int unsigned lsb);
        logic [31:0] s;
        s = 32'($signed(v) >>> lsb);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Stream interface of the instruction encoder: immediate/format input side and
// encoded word/address output side.
interface inst_encoder_if #(
    parameter int ADDR_W   = 10,
    parameter int ERRCNT_W = 8
);
    logic                i_valid;
    logic                o_ready;
    logic [2:0]          i_immSrc;
    logic [31:0]         i_imm;
    logic [31:0]         i_base;
    logic                o_valid;
    logic                i_ready;
    logic [31:0]         o_inst;
    logic [ADDR_W-1:0]   o_addr;
    logic                o_immErr;
    logic [ERRCNT_W-1:0] o_errCount;

    modport slave (
        input  i_valid, i_immSrc, i_imm, i_base, i_ready,
        output o_ready, o_valid, o_inst, o_addr, o_immErr, o_errCount
    );

    modport master (
        output i_valid, i_immSrc, i_imm, i_base, i_ready,
        input  o_ready, o_valid, o_inst, o_addr, o_immErr, o_errCount
    );
endinterface

// File: rtl/imm_field_pack.sv
// Combinational packer: scatters an immediate into its format's bit positions
// over a base instruction and flags immediates that do not fit the format.
module imm_field_pack
    import imm_pkg::*;
(
    input  logic [2:0]  src,
    input  logic [31:0] imm,
    input  logic [31:0] base,
    output logic [31:0] inst,
    output logic        err
);

    always_comb begin
        inst = base;
        err  = 1'b0;
        case (src)
            IMM_I_LOAD, IMM_I_ALU, IMM_I_JALR: begin
                inst[31:20] = imm[11:0];
                err         = !upper_uniform(imm, 11);
            end
            IMM_SHAMT: begin
                inst[24:20] = imm[4:0];
                err         = (imm[31:5] != '0);
            end
            IMM_S: begin
                inst[31:25] = imm[11:5];
                inst[11:7]  = imm[4:0];
                err         = !upper_uniform(imm, 11);
            end
            IMM_U: begin
                inst[31:12] = imm[31:12];
                err         = (imm[11:0] != '0);
            end
            IMM_B: begin
                inst[31]    = imm[12];
                inst[30:25] = imm[10:5];
                inst[11:8]  = imm[4:1];
                inst[7]     = imm[11];
                err         = imm[0] || !upper_uniform(imm, 12);
            end
            IMM_J: begin
                inst[31]    = imm[20];
                inst[30:21] = imm[10:1];
                inst[20]    = imm[11];
                inst[19:12] = imm[19:12];
                err         = imm[0] || !upper_uniform(imm, 20);
            end
            default: begin
                inst = base;
                err  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready instruction encoder feeding instruction-memory fill logic,
// with a wrapping word-address counter and a saturating immediate-error counter.
module inst_encoder
    import imm_pkg::*;
#(
    parameter int  DEPTH    = 1024,
    parameter int  ERRCNT_W = 8,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input logic            i_clk,
    input logic            i_rst_n,
    input logic            i_clear,
    inst_encoder_if.slave  bus
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    logic                s1_valid;
    enc_req_t            s1_req;
    logic                s2_valid;
    logic [31:0]         s2_inst;
    logic                s2_err;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [ERRCNT_W-1:0] err_cnt;
    logic [31:0]         pack_inst;
    logic                pack_err;
    logic                out_fire;
    logic                s2_open;
    logic                s1_fire;
    logic                in_fire;

    // Ready depends only on stage occupancy and the sink, never on i_valid.
    assign out_fire    = s2_valid & bus.i_ready;
    assign s2_open     = !s2_valid | out_fire;
    assign s1_fire     = s1_valid & s2_open;
    assign bus.o_ready = !i_clear & (!s1_valid | s2_open);
    assign in_fire     = bus.i_valid & bus.o_ready;

    imm_field_pack u_pack (
        .src  (s1_req.src),
        .imm  (s1_req.imm),
        .base (s1_req.base),
        .inst (pack_inst),
        .err  (pack_err)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_req   <= '0;
        end else if (i_clear) begin
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_req   <= '{src: bus.i_immSrc, imm: bus.i_imm, base: bus.i_base};
        end else if (s1_fire) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid <= 1'b0;
            s2_inst  <= '0;
            s2_err   <= 1'b0;
        end else if (i_clear) begin
            s2_valid <= 1'b0;
        end else if (s2_open) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_inst <= pack_inst;
                s2_err  <= pack_err;
            end
        end
    end

    // Both counters advance only on a delivered word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_cnt <= '0;
            err_cnt  <= '0;
        end else if (i_clear) begin
            addr_cnt <= '0;
            err_cnt  <= '0;
        end else if (out_fire) begin
            addr_cnt <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + ADDR_W'(1);
            if (s2_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERRCNT_W'(1);
            end
        end
    end

    assign bus.o_valid    = s2_valid;
    assign bus.o_inst     = s2_inst;
    assign bus.o_immErr   = s2_err;
    assign bus.o_addr     = addr_cnt;
    assign bus.o_errCount = err_cnt;

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction-word encoder: the write-side counterpart of the decode-stage immediate extender. It accepts an immediate value and a 3-bit immediate format code, inserts the immediate into the format's scattered bit positions of a partially built 32-bit instruction word, range-checks it, and streams the result with an incrementing word address toward instruction-memory fill logic (boot loader, self-test program generator). It has a two-stage valid/ready pipeline, a wrapping address counter and a saturating error counter.

## Interface
- DEPTH, 1024, instruction memory depth in words; ADDR_W = $clog2(DEPTH)
- ERRCNT_W, 8, width of saturating error counter
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_clear  in  1  synchronous flush of pipeline and counters
- i_valid  in  1  input word valid
- o_ready  out  1  input accepted when i_valid & o_ready
- i_immSrc  in  3  immediate format code
- i_imm  in  32  immediate value, two's complement byte offset/value
- i_base  in  32  instruction with opcode/rd/rs1/rs2/funct fields set; immediate positions ignored
- o_valid  out  1  output word valid
- i_ready  in  1  sink accepts when o_valid & i_ready
- o_inst  out  32  encoded instruction
- o_addr  out  ADDR_W  word address of o_inst
- o_immErr  out  1  immediate did not fit the format (qualified by o_valid)
- o_errCount  out  ERRCNT_W  count of delivered words with o_immErr set

## Operation
- Format codes and bit placement (bits not listed come from i_base):
  - 000 I-load, 001 I-alu, 110 I-jalr: inst[31:20]=imm[11:0]; err unless imm[31:11] all equal
  - 010 shamt: inst[24:20]=imm[4:0]; inst[31:25] from i_base; err unless imm[31:5]==0
  - 011 S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]; err as I
  - 100 U: inst[31:12]=imm[31:12]; err unless imm[11:0]==0
  - 101 B: inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11]; err unless imm[0]==0 and imm[31:12] all equal
  - 111 J: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12]; err unless imm[0]==0 and imm[31:20] all equal
- Out-of-range: word still encoded from the truncated bits and delivered; o_immErr=1 with it.
- Stage 1 registers the input (immSrc, imm, base); stage 2 registers packed inst, err flag and address.
- o_addr: counter starts 0, increments on each output handshake, DEPTH-1 wraps to 0.
- o_errCount: increments on output handshake with o_immErr=1; saturates at all-ones.
- i_clear: both stages invalidated, o_addr and o_errCount to 0; o_ready=0 that cycle, so no input is accepted.

## Timing
- Reset values: o_valid=0, o_ready=1, o_inst=0, o_addr=0, o_immErr=0, o_errCount=0; stages empty.
- Latency: input accepted in cycle N appears on o_valid in cycle N+2 with i_ready high.
- Throughput: one word per cycle under continuous i_ready.
- A stage loads when it is empty or its content moves on the same cycle; o_ready = !i_clear & (stage1 empty | stage1 advancing). No combinational path from i_valid to o_ready.
- With i_ready low, at most 2 words are held; o_ready falls once both stages are full. No loss, duplication or reordering.
- o_inst/o_addr/o_immErr stable while o_valid & !i_ready.
- Output handshake and new input in the same cycle: both take effect.
- Reset asserted mid-stream: pipeline contents dropped immediately, outputs at reset values.

## Structure
- Shared package imm_pkg: localparams for the eight immSrc codes, shared with the decode-side immediate extender so the encodings agree.
- Sub-module imm_field_pack: combinational (immSrc, imm, base) -> (inst, err). The pipeline, handshake and counters live in inst_encoder.

## Test plan
- I-alu: base 0x00000013, imm 0xFFFFFFFF, src 001 -> o_inst 0xFFF00013, o_immErr 0, o_addr 0, o_valid two cycles after accept.
- S and B: base 0x00002023, imm 0xFFFFFFFC, src 011 -> 0xFE002E23; base 0x00000063, imm 8, src 101 -> 0x00000463; J base 0x0000006F, imm 0x800 -> 0x0010006F.
- Errors: src 101, imm 7 -> o_immErr 1, o_errCount 1; src 000, imm 0x800 -> o_immErr 1, o_errCount 2; errCount held at 255 after further errors (ERRCNT_W=8).
- Backpressure: 3 back-to-back inputs, i_ready low 5 cycles -> o_ready low after 2 accepts; on release, words delivered in order at o_addr 0,1,2.
- Wrap: DEPTH=4, 5 words -> o_addr 0,1,2,3,0.
- Clear/reset: both stages full, pulse i_clear -> next cycle o_valid 0, o_addr 0, o_errCount 0. Drop i_rst_n mid-stream -> all outputs at reset values without a clock edge.
